// File: rtl/clkdiv_gate_pkg.sv
// Shared types and limits for the glitch-free clock divider/gate.
package clkdiv_gate_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    localparam int DIV_W_MAX = 16;

endpackage

// File: rtl/clkdiv_gate_if.sv
// Divide-ratio valid/ready channel into clkdiv_gate.
interface clkdiv_gate_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] DIV;
    logic             DIV_VLD;
    logic             DIV_RDY;

    modport master (output DIV, output DIV_VLD, input DIV_RDY);
    modport slave  (input DIV, input DIV_VLD, output DIV_RDY);

endinterface

// File: rtl/clkdiv_gate_cnt.sv
// Half-period counter: clears on request, wraps to 0 at terminal count.
module clkdiv_gate_cnt
    import clkdiv_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] lim_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc_o  = (cnt_q == lim_i);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clkdiv_gate.sv
// Glitch-free programmable clock divider/gate feeding the clkbuf I pin.
// Optional TICK output: GF180MCU_FD_SC_MCU9T5V0_CLKDIV_TICK_EN.
module clkdiv_gate
    import clkdiv_gate_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIV_RST = 0
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    clkdiv_gate_if.slave dif,
`ifdef GF180MCU_FD_SC_MCU9T5V0_CLKDIV_TICK_EN
    output logic TICK,
`endif
    output logic Z,
    output logic RUNNING
);

    if (WIDTH > DIV_W_MAX) begin : g_width_chk
        $error("clkdiv_gate: WIDTH exceeds DIV_W_MAX");
    end

    state_t           state_q;
    state_t           nxt;
    logic             z_q;
    logic             running_q;
    logic             pending_q;
    logic [WIDTH-1:0] div_cur_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             tog;
    logic             fall;
    logic             xfer;
    logic             go_idle;
    logic             cnt_clr;

    clkdiv_gate_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (cnt_clr),
        .lim_i (div_cur_q),
        .cnt_o (cnt),
        .tc_o  (tc)
    );

    // A high phase is never cut short: with Z=1 and EN low we
    // finish the phase in STOP before parking in IDLE.
    always_comb begin
        nxt = state_q;
        tog = 1'b0;
        case (state_q)
            IDLE: nxt = EN ? RUN : IDLE;
            RUN: begin
                if (EN) begin
                    tog = tc;
                end else if (!z_q) begin
                    nxt = IDLE;
                end else begin
                    tog = tc;
                    nxt = tc ? IDLE : STOP;
                end
            end
            STOP: begin
                tog = tc;
                if (EN) begin
                    nxt = RUN;
                end else if (tc) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign fall    = tog & z_q;
    assign xfer    = dif.DIV_VLD & ~pending_q;
    assign go_idle = (nxt == IDLE);
    assign cnt_clr = (state_q == IDLE) | go_idle;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            z_q       <= 1'b0;
            running_q <= 1'b0;
            pending_q <= 1'b0;
            div_cur_q <= WIDTH'(DIV_RST);
            shadow_q  <= '0;
        end else begin
            state_q   <= nxt;
            z_q       <= z_q ^ tog;
            running_q <= !go_idle;
            if ((state_q == IDLE) || go_idle) begin
                pending_q <= 1'b0;
                if (xfer) begin
                    div_cur_q <= dif.DIV;
                end else if (pending_q) begin
                    div_cur_q <= shadow_q;
                end
            end else begin
                if (fall && pending_q) begin
                    div_cur_q <= shadow_q;
                    pending_q <= 1'b0;
                end
                if (xfer) begin
                    shadow_q  <= dif.DIV;
                    pending_q <= 1'b1;
                end
            end
        end
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0_CLKDIV_TICK_EN
    logic tick_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tog & ~z_q;
        end
    end

    assign TICK = tick_q;
`endif

    assign Z           = z_q;
    assign RUNNING     = running_q;
    assign dif.DIV_RDY = ~pending_q;

endmodule

// File: tb/tb_clkdiv_gate.sv
// Directed self-checking bench for clkdiv_gate.
module tb_clkdiv_gate;
    import clkdiv_gate_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic z;
    logic running;
`ifdef GF180MCU_FD_SC_MCU9T5V0_CLKDIV_TICK_EN
    logic tick;
`endif
    int checks   = 0;
    int failures = 0;

    clkdiv_gate_if #(.WIDTH(8)) dif ();

    clkdiv_gate #(
        .WIDTH   (8),
        .DIV_RST (0)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .EN      (en),
        .dif     (dif),
`ifdef GF180MCU_FD_SC_MCU9T5V0_CLKDIV_TICK_EN
        .TICK    (tick),
`endif
        .Z       (z),
        .RUNNING (running)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        dif.DIV = '0;
        dif.DIV_VLD = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (z !== 1'b0 || running !== 1'b0 || dif.DIV_RDY !== 1'b1
                || dut.div_cur_q !== 8'd0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d z=%b run=%b rdy=%b div=%0d want 0 0 1 0",
                         i, z, running, dif.DIV_RDY, dut.div_cur_q);
            end
        end
    endtask

    task automatic test_run_div2();
        logic [11:0] ez;
        ez = 12'b001110001110;
        dif.DIV = 8'd2;
        dif.DIV_VLD = 1'b1;
        step();
        dif.DIV_VLD = 1'b0;
        checks++;
        if (dut.div_cur_q !== 8'd2 || dif.DIV_RDY !== 1'b1) begin
            failures++;
            $display("FAIL idle_load div=%0d rdy=%b want 2 1", dut.div_cur_q, dif.DIV_RDY);
        end
        en = 1'b1;
        step();
        checks++;
        if (running !== 1'b1 || z !== 1'b0) begin
            failures++;
            $display("FAIL enter_run run=%b z=%b want 1 0", running, z);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (z !== ez[11-i] || running !== 1'b1) begin
                failures++;
                $display("FAIL div2_wave edge=%0d z=%b run=%b want %b 1",
                         i + 1, z, running, ez[11-i]);
            end
        end
    endtask

    task automatic test_ratio_change();
        logic [5:0] ez;
        ez = 6'b101010;
        repeat (3) step();
        checks++;
        if (z !== 1'b1) begin
            failures++;
            $display("FAIL ratio_pre_rise z=%b want 1", z);
        end
        step();
        dif.DIV = 8'd0;
        dif.DIV_VLD = 1'b1;
        step();
        dif.DIV_VLD = 1'b0;
        checks++;
        if (dif.DIV_RDY !== 1'b0 || z !== 1'b1 || dut.div_cur_q !== 8'd2) begin
            failures++;
            $display("FAIL ratio_pending rdy=%b z=%b div=%0d want 0 1 2",
                     dif.DIV_RDY, z, dut.div_cur_q);
        end
        step();
        checks++;
        if (z !== 1'b0 || dif.DIV_RDY !== 1'b1 || dut.div_cur_q !== 8'd0) begin
            failures++;
            $display("FAIL ratio_apply z=%b rdy=%b div=%0d want 0 1 0",
                     z, dif.DIV_RDY, dut.div_cur_q);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (z !== ez[5-i]) begin
                failures++;
                $display("FAIL div0_wave edge=%0d z=%b want %b", i, z, ez[5-i]);
            end
        end
    endtask

    task automatic test_stop();
        logic [3:0]  ez4;
        logic [10:0] ez11;
        ez4 = 4'b0001;
        ez11 = 11'b10000111100;
        en = 1'b0;
        step();
        checks++;
        if (running !== 1'b0 || z !== 1'b0) begin
            failures++;
            $display("FAIL stop_low_idle run=%b z=%b want 0 0", running, z);
        end
        dif.DIV = 8'd3;
        dif.DIV_VLD = 1'b1;
        en = 1'b1;
        step();
        dif.DIV_VLD = 1'b0;
        checks++;
        if (dut.div_cur_q !== 8'd3 || running !== 1'b1 || z !== 1'b0) begin
            failures++;
            $display("FAIL load_with_en div=%0d run=%b z=%b want 3 1 0",
                     dut.div_cur_q, running, z);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (z !== ez4[3-i]) begin
                failures++;
                $display("FAIL div3_first_rise edge=%0d z=%b want %b", i + 1, z, ez4[3-i]);
            end
        end
        step();
        en = 1'b0;
        step();
        checks++;
        if (z !== 1'b1 || running !== 1'b1 || dut.state_q !== STOP) begin
            failures++;
            $display("FAIL stop_enter z=%b run=%b st=%0d want 1 1 %0d",
                     z, running, dut.state_q, STOP);
        end
        step();
        checks++;
        if (z !== 1'b1) begin
            failures++;
            $display("FAIL stop_hold z=%b want 1", z);
        end
        step();
        checks++;
        if (z !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL stop_fall z=%b run=%b want 0 0", z, running);
        end
        step();
        checks++;
        if (z !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL stop_parked z=%b run=%b want 0 0", z, running);
        end
        en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (z !== ez4[3-i]) begin
                failures++;
                $display("FAIL rerun_rise edge=%0d z=%b want %b", i + 1, z, ez4[3-i]);
            end
        end
        step();
        en = 1'b0;
        step();
        checks++;
        if (z !== 1'b1 || dut.state_q !== STOP) begin
            failures++;
            $display("FAIL stop2_enter z=%b st=%0d want 1 %0d", z, dut.state_q, STOP);
        end
        en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            checks++;
            if (z !== ez11[10-i] || running !== 1'b1) begin
                failures++;
                $display("FAIL resume_wave edge=%0d z=%b run=%b want %b 1",
                         i + 7, z, running, ez11[10-i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (z === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rst_mid_wait z=%b want 1 within 8 edges", z);
        end
        dif.DIV = 8'd5;
        dif.DIV_VLD = 1'b1;
        step();
        dif.DIV_VLD = 1'b0;
        checks++;
        if (dif.DIV_RDY !== 1'b0 || z !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pending rdy=%b z=%b want 0 1", dif.DIV_RDY, z);
        end
        en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (z !== 1'b0 || running !== 1'b0 || dif.DIV_RDY !== 1'b1
            || dut.div_cur_q !== 8'd0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL rst_mid z=%b run=%b rdy=%b div=%0d st=%0d want 0 0 1 0 %0d",
                     z, running, dif.DIV_RDY, dut.div_cur_q, dut.state_q, IDLE);
        end
        step();
        checks++;
        if (z !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_after z=%b run=%b want 0 0", z, running);
        end
    endtask

    task automatic test_tick();
        logic [11:0] ez;
        logic [11:0] et;
        ez = 12'b011001100110;
        et = 12'b010001000100;
        dif.DIV = 8'd1;
        dif.DIV_VLD = 1'b1;
        en = 1'b1;
        step();
        dif.DIV_VLD = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (z !== ez[11-i]) begin
                failures++;
                $display("FAIL div1_wave edge=%0d z=%b want %b", i + 1, z, ez[11-i]);
            end
`ifdef GF180MCU_FD_SC_MCU9T5V0_CLKDIV_TICK_EN
            checks++;
            if (tick !== et[11-i]) begin
                failures++;
                $display("FAIL tick edge=%0d tick=%b want %b", i + 1, tick, et[11-i]);
            end
`else
            if (et[11-i] === 1'b1) begin
                checks++;
                if (z !== 1'b1) begin
                    failures++;
                    $display("FAIL rise_align edge=%0d z=%b want 1", i + 1, z);
                end
            end
`endif
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_div2();
        test_ratio_change();
        test_stop();
        test_reset_mid();
        test_tick();
        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
